scarv_integ_cop_ifreg: RTL and testbench

Register slice and sequencer between the CPU-side XCrypto co-processor instruction interface (driven by the PCPI-to-COP converter) and the XCrypto COP core. It takes one instruction per request/acknowledge handshake, registers it for the core, captures the core's writeback and result, and holds the response until the CPU side acknowledges it. This cuts every combinational path between CPU and core. Two saturation-free performance counters are included.

---
 rtl/scarv_integ_cop_ifreg.sv | 132 +++++++++++++
 tb/tb_scarv_integ_cop_ifreg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_integ_cop_ifreg.sv
// Register slice between the CPU-side XCrypto COP instruction port and the COP core.
// One instruction in flight; request and response are fully registered in both directions.
//
// state | meaning
// IDLE  | ready to accept a CPU request (cop_insn_ack=1)
// ISSUE | presenting the registered instruction to the core
// WAIT  | waiting for the core response (core_rsp_ack=1)
// RESP  | presenting the registered result to the CPU
// TURN  | one dead cycle so a still-held request is not re-accepted
module scarv_integ_cop_ifreg #(
   parameter int COUNT_W = 32
) (
   input  logic               g_clk,
   input  logic               g_resetn,
   input  logic               cpu_insn_req,
   output logic               cop_insn_ack,
   input  logic [31:0]        cpu_insn_enc,
   input  logic [31:0]        cpu_rs1,
   input  logic [31:0]        cpu_rs2,
   output logic               cop_wen,
   output logic [4:0]         cop_waddr,
   output logic [31:0]        cop_wdata,
   output logic [2:0]         cop_result,
   output logic               cop_insn_rsp,
   input  logic               cpu_insn_ack,
   output logic               core_insn_req,
   input  logic               core_insn_ack,
   output logic [31:0]        core_insn_enc,
   output logic [31:0]        core_rs1,
   output logic [31:0]        core_rs2,
   input  logic               core_wen,
   input  logic [4:0]         core_waddr,
   input  logic [31:0]        core_wdata,
   input  logic [2:0]         core_result,
   input  logic               core_insn_rsp,
   output logic               core_rsp_ack,
   input  logic               perf_clr,
   output logic [COUNT_W-1:0] perf_insns,
   output logic [COUNT_W-1:0] perf_busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      TURN  = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic accept;
   logic take_rsp;
   logic deliver;

   assign cop_insn_ack  = (state == IDLE);
   assign core_insn_req = (state == ISSUE);
   assign core_rsp_ack  = (state == WAIT);
   assign cop_insn_rsp  = (state == RESP);

   assign accept   = (state == IDLE) && cpu_insn_req;
   assign take_rsp = (state == WAIT) && core_insn_rsp;
   assign deliver  = (state == RESP) && cpu_insn_ack;

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cpu_insn_req)  state_nxt = ISSUE;
         ISSUE:   if (core_insn_ack) state_nxt = WAIT;
         WAIT:    if (core_insn_rsp) state_nxt = RESP;
         RESP:    if (cpu_insn_ack)  state_nxt = TURN;
         TURN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         core_insn_enc <= '0;
         core_rs1      <= '0;
         core_rs2      <= '0;
      end else if (accept) begin
         core_insn_enc <= cpu_insn_enc;
         core_rs1      <= cpu_rs1;
         core_rs2      <= cpu_rs2;
      end
   end

   // cop_wen is only ever set on entry to RESP and cleared on leaving it,
   // so it reads 0 in every other state; the data fields simply hold.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         cop_wen    <= 1'b0;
         cop_waddr  <= '0;
         cop_wdata  <= '0;
         cop_result <= '0;
      end else if (take_rsp) begin
         cop_wen    <= core_wen;
         cop_waddr  <= core_waddr;
         cop_wdata  <= core_wdata;
         cop_result <= core_result;
      end else if (deliver) begin
         cop_wen    <= 1'b0;
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn || perf_clr) begin
         perf_insns <= '0;
      end else if (deliver) begin
         perf_insns <= perf_insns + COUNT_W'(1);
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn || perf_clr) begin
         perf_busy <= '0;
      end else if (state != IDLE) begin
         perf_busy <= perf_busy + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_scarv_integ_cop_ifreg.sv
// Directed and randomized bench for scarv_integ_cop_ifreg; a 4-bit-counter
// instance runs in lockstep to exercise counter wrap.
module tb_scarv_integ_cop_ifreg;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        cpu_insn_req;
   logic [31:0] cpu_insn_enc;
   logic [31:0] cpu_rs1;
   logic [31:0] cpu_rs2;
   logic        cpu_insn_ack;
   logic        core_insn_ack;
   logic        core_wen;
   logic [4:0]  core_waddr;
   logic [31:0] core_wdata;
   logic [2:0]  core_result;
   logic        core_insn_rsp;
   logic        perf_clr;

   logic        cop_insn_ack;
   logic        cop_wen;
   logic [4:0]  cop_waddr;
   logic [31:0] cop_wdata;
   logic [2:0]  cop_result;
   logic        cop_insn_rsp;
   logic        core_insn_req;
   logic [31:0] core_insn_enc;
   logic [31:0] core_rs1;
   logic [31:0] core_rs2;
   logic        core_rsp_ack;
   logic [31:0] perf_insns;
   logic [31:0] perf_busy;

   logic        n_cop_insn_ack;
   logic        n_cop_wen;
   logic [4:0]  n_cop_waddr;
   logic [31:0] n_cop_wdata;
   logic [2:0]  n_cop_result;
   logic        n_cop_insn_rsp;
   logic        n_core_insn_req;
   logic [31:0] n_core_insn_enc;
   logic [31:0] n_core_rs1;
   logic [31:0] n_core_rs2;
   logic        n_core_rsp_ack;
   logic [3:0]  n_perf_insns;
   logic [3:0]  n_perf_busy;

   scarv_integ_cop_ifreg #(.COUNT_W(32)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
      .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
      .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
      .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
      .core_insn_req(core_insn_req), .core_insn_ack(core_insn_ack),
      .core_insn_enc(core_insn_enc), .core_rs1(core_rs1), .core_rs2(core_rs2),
      .core_wen(core_wen), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_result(core_result), .core_insn_rsp(core_insn_rsp), .core_rsp_ack(core_rsp_ack),
      .perf_clr(perf_clr), .perf_insns(perf_insns), .perf_busy(perf_busy)
   );

   scarv_integ_cop_ifreg #(.COUNT_W(4)) dut_narrow (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cpu_insn_req(cpu_insn_req), .cop_insn_ack(n_cop_insn_ack),
      .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
      .cop_wen(n_cop_wen), .cop_waddr(n_cop_waddr), .cop_wdata(n_cop_wdata),
      .cop_result(n_cop_result), .cop_insn_rsp(n_cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
      .core_insn_req(n_core_insn_req), .core_insn_ack(core_insn_ack),
      .core_insn_enc(n_core_insn_enc), .core_rs1(n_core_rs1), .core_rs2(n_core_rs2),
      .core_wen(core_wen), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_result(core_result), .core_insn_rsp(core_insn_rsp), .core_rsp_ack(n_core_rsp_ack),
      .perf_clr(perf_clr), .perf_insns(n_perf_insns), .perf_busy(n_perf_busy)
   );

   always #5 g_clk = ~g_clk;

   int checks = 0;
   int failures = 0;

   // Reference counters: responses delivered and non-idle cycles since last clear.
   logic [31:0] exp_insns = '0;
   logic [31:0] exp_busy  = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   // One complete transaction. The core acks after ack_dly stall cycles, responds
   // after rsp_dly, and the CPU acks after cpu_dly. Inputs are scrambled while the
   // block is supposed to be holding, to prove the registers are stable.
   task automatic run_insn(input int ack_dly, input int rsp_dly, input int cpu_dly,
                           input bit clr, input bit hold,
                           input logic [31:0] enc, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [2:0] result);
      chk("idle_ack", 64'(cop_insn_ack), 64'(1));
      cpu_insn_req = 1'b1;
      cpu_insn_enc = enc;
      cpu_rs1      = rs1;
      cpu_rs2      = rs2;
      tick();
      cpu_insn_enc = $urandom;
      cpu_rs1      = $urandom;
      cpu_rs2      = $urandom;
      chk("issue_req", 64'(core_insn_req), 64'(1));
      chk("issue_enc", 64'(core_insn_enc), 64'(enc));
      chk("issue_rs1", 64'(core_rs1), 64'(rs1));
      chk("issue_rs2", 64'(core_rs2), 64'(rs2));
      chk("issue_cop_ack", 64'(cop_insn_ack), 64'(0));
      chk("issue_rsp", 64'(cop_insn_rsp), 64'(0));
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         chk("stall_req", 64'(core_insn_req), 64'(1));
         chk("stall_enc", 64'(core_insn_enc), 64'(enc));
         chk("stall_rs2", 64'(core_rs2), 64'(rs2));
         chk("stall_rsp_ack", 64'(core_rsp_ack), 64'(0));
      end
      core_insn_ack = 1'b1;
      tick();
      core_insn_ack = 1'b0;
      chk("wait_req", 64'(core_insn_req), 64'(0));
      chk("wait_rsp_ack", 64'(core_rsp_ack), 64'(1));
      chk("wait_rsp", 64'(cop_insn_rsp), 64'(0));
      for (int i = 0; i < rsp_dly; i++) begin
         core_wen   = 1'b1;
         core_wdata = $urandom;
         tick();
         chk("wstall_rsp_ack", 64'(core_rsp_ack), 64'(1));
         chk("wstall_rsp", 64'(cop_insn_rsp), 64'(0));
         chk("wstall_wen", 64'(cop_wen), 64'(0));
         chk("wstall_enc", 64'(core_insn_enc), 64'(enc));
      end
      core_wen      = wen;
      core_waddr    = waddr;
      core_wdata    = wdata;
      core_result   = result;
      core_insn_rsp = 1'b1;
      tick();
      core_insn_rsp = 1'b0;
      core_wen      = ~wen;
      core_waddr    = 5'($urandom);
      core_wdata    = $urandom;
      core_result   = 3'($urandom);
      chk("resp_valid", 64'(cop_insn_rsp), 64'(1));
      chk("resp_wen", 64'(cop_wen), 64'(wen));
      chk("resp_waddr", 64'(cop_waddr), 64'(waddr));
      chk("resp_wdata", 64'(cop_wdata), 64'(wdata));
      chk("resp_result", 64'(cop_result), 64'(result));
      chk("resp_rsp_ack", 64'(core_rsp_ack), 64'(0));
      for (int i = 0; i < cpu_dly; i++) begin
         tick();
         chk("rstall_valid", 64'(cop_insn_rsp), 64'(1));
         chk("rstall_wen", 64'(cop_wen), 64'(wen));
         chk("rstall_wdata", 64'(cop_wdata), 64'(wdata));
         chk("rstall_result", 64'(cop_result), 64'(result));
      end
      cpu_insn_ack = 1'b1;
      perf_clr     = clr;
      tick();
      cpu_insn_ack = 1'b0;
      perf_clr     = 1'b0;
      exp_insns = clr ? 32'd0 : exp_insns + 32'd1;
      exp_busy  = clr ? 32'd0 : exp_busy + 32'(3 + ack_dly + rsp_dly + cpu_dly);
      chk("turn_cop_ack", 64'(cop_insn_ack), 64'(0));
      chk("turn_rsp", 64'(cop_insn_rsp), 64'(0));
      chk("turn_wen", 64'(cop_wen), 64'(0));
      chk("turn_insns", 64'(perf_insns), 64'(exp_insns));
      chk("turn_busy", 64'(perf_busy), 64'(exp_busy));
      chk("turn_insns4", 64'(n_perf_insns), 64'(exp_insns[3:0]));
      if (hold) cpu_insn_enc = $urandom;
      else      cpu_insn_req = 1'b0;
      tick();
      exp_busy = exp_busy + 32'd1;
      chk("idle_back_ack", 64'(cop_insn_ack), 64'(1));
      chk("idle_no_relatch", 64'(core_insn_enc), 64'(enc));
      chk("idle_busy", 64'(perf_busy), 64'(exp_busy));
      chk("idle_busy4", 64'(n_perf_busy), 64'(exp_busy[3:0]));
      chk("idle_waddr_hold", 64'(cop_waddr), 64'(waddr));
      chk("idle_wdata_hold", 64'(cop_wdata), 64'(wdata));
      chk("idle_result_hold", 64'(cop_result), 64'(result));
      chk("idle_req", 64'(core_insn_req), 64'(0));
   endtask

   task automatic run_random(input int max_dly, input bit clr);
      run_insn($urandom_range(0, max_dly), $urandom_range(0, max_dly), $urandom_range(0, max_dly),
               clr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               1'($urandom_range(0, 1)), 5'($urandom), $urandom, 3'($urandom));
   endtask

   initial begin
      g_resetn      = 1'b0;
      cpu_insn_req  = 1'b0;
      cpu_insn_enc  = '0;
      cpu_rs1       = '0;
      cpu_rs2       = '0;
      cpu_insn_ack  = 1'b0;
      core_insn_ack = 1'b0;
      core_wen      = 1'b0;
      core_waddr    = '0;
      core_wdata    = '0;
      core_result   = '0;
      core_insn_rsp = 1'b0;
      perf_clr      = 1'b0;

      // Reset
      tick(); tick(); tick();
      g_resetn = 1'b1;
      tick();
      chk("rst_cop_ack", 64'(cop_insn_ack), 64'(1));
      chk("rst_wen", 64'(cop_wen), 64'(0));
      chk("rst_waddr", 64'(cop_waddr), 64'(0));
      chk("rst_wdata", 64'(cop_wdata), 64'(0));
      chk("rst_result", 64'(cop_result), 64'(0));
      chk("rst_rsp", 64'(cop_insn_rsp), 64'(0));
      chk("rst_core_req", 64'(core_insn_req), 64'(0));
      chk("rst_core_enc", 64'(core_insn_enc), 64'(0));
      chk("rst_core_rs1", 64'(core_rs1), 64'(0));
      chk("rst_core_rs2", 64'(core_rs2), 64'(0));
      chk("rst_rsp_ack", 64'(core_rsp_ack), 64'(0));
      chk("rst_insns", 64'(perf_insns), 64'(0));
      chk("rst_busy", 64'(perf_busy), 64'(0));

      // Back-to-back minimum latency path
      run_insn(0, 0, 0, 1'b0, 1'b0, 32'h0000_702B, 32'h1234_5678, 32'h9ABC_DEF0,
               1'b1, 5'd5, 32'hCAFE_F00D, 3'd0);
      chk("b2b_insns", 64'(perf_insns), 64'(1));
      chk("b2b_busy", 64'(perf_busy), 64'(4));

      // Stalls on every handshake
      run_insn(7, 10, 4, 1'b0, 1'b0, 32'h0000_112B, 32'hA5A5_0001, 32'h5A5A_0002,
               1'b1, 5'd17, 32'h0BAD_BEEF, 3'd3);
      chk("stall_insns", 64'(perf_insns), 64'(2));

      // Request held through TURN, re-accepted in IDLE
      run_insn(0, 0, 0, 1'b0, 1'b1, 32'h1111_0000, 32'h1, 32'h2, 1'b0, 5'd1, 32'h3, 3'd1);
      run_insn(1, 0, 0, 1'b0, 1'b0, 32'h2222_0000, 32'h4, 32'h5, 1'b1, 5'd2, 32'h6, 3'd2);

      // Reset in WAIT discards the instruction
      cpu_insn_req = 1'b1;
      cpu_insn_enc = 32'hDEAD_0001;
      tick();
      core_insn_ack = 1'b1;
      tick();
      core_insn_ack = 1'b0;
      chk("mid_wait_rsp_ack", 64'(core_rsp_ack), 64'(1));
      g_resetn     = 1'b0;
      cpu_insn_req = 1'b0;
      tick();
      g_resetn  = 1'b1;
      exp_insns = '0;
      exp_busy  = '0;
      chk("mid_rst_cop_ack", 64'(cop_insn_ack), 64'(1));
      chk("mid_rst_rsp_ack", 64'(core_rsp_ack), 64'(0));
      chk("mid_rst_rsp", 64'(cop_insn_rsp), 64'(0));
      chk("mid_rst_core_req", 64'(core_insn_req), 64'(0));
      chk("mid_rst_enc", 64'(core_insn_enc), 64'(0));
      chk("mid_rst_insns", 64'(perf_insns), 64'(0));
      chk("mid_rst_busy", 64'(perf_busy), 64'(0));
      tick();

      // Clear wins over a same-cycle increment
      for (int i = 0; i < 3; i++) run_random(2, 1'b0);
      chk("preload_insns", 64'(perf_insns), 64'(3));
      run_random(2, 1'b1);
      chk("clr_insns", 64'(perf_insns), 64'(0));

      // 16 deliveries wrap the 4-bit counter
      perf_clr = 1'b1;
      tick();
      perf_clr  = 1'b0;
      exp_insns = '0;
      exp_busy  = '0;
      chk("idle_clr_busy", 64'(perf_busy), 64'(0));
      for (int i = 0; i < 16; i++) run_random(2, 1'b0);
      chk("wrap_insns32", 64'(perf_insns), 64'(16));
      chk("wrap_insns4", 64'(n_perf_insns), 64'(0));

      // Randomized traffic
      for (int i = 0; i < 20; i++) run_random(5, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
